// File: rtl/accl_result_accumulator_pkg.sv
// Shared accelerator types and constants used by the result accumulator
// and its output FIFO.
package AcceleratorPackage;

  localparam int AcclDataWidth = 32;
  localparam int FilterRowSize = 2;
  localparam int OutFifoDepth  = 16;

  typedef logic signed [AcclDataWidth-1:0] AcclDataType;

  typedef enum logic {
    s_Accum = 1'b0,
    s_Stall = 1'b1
  } AccumStateType;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/accl_result_accumulator_out_fifo.sv
// Show-ahead output FIFO: array storage with a registered head word that is
// refreshed every edge from the next read address.
module accl_out_fifo
  import AcceleratorPackage::*;
#(
  parameter int DataWidth = 32,
  parameter int Depth     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DataWidth-1:0]   pushData,
  input  logic                   pop,
  output logic [DataWidth-1:0]   headData,
  output logic [clog2(Depth):0]  count,
  output logic                   empty,
  output logic                   full
);

  localparam int PtrWidth   = clog2(Depth);
  localparam int CountWidth = PtrWidth + 1;

  logic [DataWidth-1:0]  mem [Depth];
  logic [DataWidth-1:0]  headReg;
  logic [PtrWidth-1:0]   wrPtrReg;
  logic [PtrWidth-1:0]   rdPtrReg;
  logic [PtrWidth-1:0]   rdPtrNext;
  logic [CountWidth-1:0] countReg;
  logic                  doPush;
  logic                  doPop;

  assign empty    = (countReg == '0);
  assign full     = (countReg == CountWidth'(Depth));
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign rdPtrNext = doPop ? rdPtrReg + 1'b1 : rdPtrReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (clear) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) begin
        wrPtrReg <= wrPtrReg + 1'b1;
      end
      rdPtrReg <= rdPtrNext;
      case ({doPush, doPop})
        2'b10:   countReg <= countReg + 1'b1;
        2'b01:   countReg <= countReg - 1'b1;
        default: countReg <= countReg;
      endcase
    end
  end

  // A word written to the slot about to become the head must bypass the array.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtrReg] <= pushData;
    end
    if (doPush && (wrPtrReg == rdPtrNext)) begin
      headReg <= pushData;
    end else begin
      headReg <= mem[rdPtrNext];
    end
  end

  assign headData = empty ? '0 : headReg;
  assign count    = countReg;

endmodule

// File: rtl/accl_result_accumulator.sv
// Accumulates MAC partial sums per filter row, saturates/ReLU-clamps the row
// total and queues it in the output FIFO, stalling the MAC when it is full.
module accl_result_accumulator
  import AcceleratorPackage::*;
#(
  parameter int DataWidth = AcclDataWidth,
  parameter int AccWidth  = 40,
  parameter int FifoDepth = OutFifoDepth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ClearIn,
  input  logic                       ResultValidIn,
  input  logic [DataWidth-1:0]       ResultIn,
  input  logic                       CellEndIn,
  input  logic                       RowEndIn,
  input  logic                       ReluEnIn,
  output logic                       StallOut,
  input  logic                       ReadEnIn,
  output logic [DataWidth-1:0]       DataOut,
  output logic [clog2(FifoDepth):0]  FifoCountOut,
  output logic                       FifoEmptyOut,
  output logic                       FifoFullOut,
  output logic [2:0]                 ErrorOut
);

  localparam int CellCountWidth = 16;
  localparam logic signed [AccWidth-1:0] SatMax =
    {{(AccWidth-DataWidth+1){1'b0}}, {(DataWidth-1){1'b1}}};
  localparam logic signed [AccWidth-1:0] SatMin =
    {{(AccWidth-DataWidth+1){1'b1}}, {(DataWidth-1){1'b0}}};

  AccumStateType             stateReg;
  AccumStateType             stateNext;
  logic [AccWidth-1:0]       accReg;
  logic [AccWidth-1:0]       accNext;
  logic [CellCountWidth-1:0] cellCountReg;
  logic [CellCountWidth-1:0] cellCountNext;
  logic [DataWidth-1:0]      pendingReg;
  logic [DataWidth-1:0]      pendingNext;
  logic [2:0]                errorReg;
  logic [2:0]                errorNext;

  logic [AccWidth-1:0]        resultExt;
  logic signed [AccWidth-1:0] sumWide;
  logic [DataWidth-1:0]       satWord;
  logic [DataWidth-1:0]       finalWord;
  logic                       fifoPush;
  logic [DataWidth-1:0]       fifoPushData;
  logic                       fifoPop;
  logic                       canPush;

  assign resultExt = {{(AccWidth-DataWidth){ResultIn[DataWidth-1]}}, ResultIn};
  assign sumWide   = $signed(accReg + resultExt);

  always_comb begin
    satWord = sumWide[DataWidth-1:0];
    if (sumWide > SatMax) begin
      satWord = SatMax[DataWidth-1:0];
    end else if (sumWide < SatMin) begin
      satWord = SatMin[DataWidth-1:0];
    end
  end

  assign finalWord = (ReluEnIn && satWord[DataWidth-1]) ? '0 : satWord;
  assign fifoPop   = ReadEnIn && !FifoEmptyOut;
  assign canPush   = !FifoFullOut || fifoPop;

  always_comb begin
    stateNext     = stateReg;
    accNext       = accReg;
    cellCountNext = cellCountReg;
    pendingNext   = pendingReg;
    errorNext     = errorReg;
    fifoPush      = 1'b0;
    fifoPushData  = finalWord;

    if (ReadEnIn && FifoEmptyOut) begin
      errorNext[1] = 1'b1;
    end

    case (stateReg)
      s_Accum: begin
        if (ResultValidIn) begin
          if (!RowEndIn) begin
            accNext = sumWide;
            if (CellEndIn) begin
              cellCountNext = cellCountReg + 1'b1;
            end
          end else begin
            accNext       = '0;
            cellCountNext = '0;
            if ((cellCountReg + 1'b1) != CellCountWidth'(FilterRowSize)) begin
              errorNext[2] = 1'b1;
            end
            if (canPush) begin
              fifoPush = 1'b1;
            end else begin
              pendingNext = finalWord;
              stateNext   = s_Stall;
            end
          end
        end
      end
      s_Stall: begin
        if (ResultValidIn) begin
          errorNext[0] = 1'b1;
        end
        // The FIFO is full here, so any pop frees exactly the slot we need.
        if (fifoPop) begin
          fifoPush     = 1'b1;
          fifoPushData = pendingReg;
          stateNext    = s_Accum;
        end
      end
      default: stateNext = s_Accum;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= s_Accum;
      accReg       <= '0;
      cellCountReg <= '0;
      pendingReg   <= '0;
      errorReg     <= '0;
    end else if (ClearIn) begin
      stateReg     <= s_Accum;
      accReg       <= '0;
      cellCountReg <= '0;
      pendingReg   <= '0;
      errorReg     <= '0;
    end else begin
      stateReg     <= stateNext;
      accReg       <= accNext;
      cellCountReg <= cellCountNext;
      pendingReg   <= pendingNext;
      errorReg     <= errorNext;
    end
  end

  accl_out_fifo #(
    .DataWidth (DataWidth),
    .Depth     (FifoDepth)
  ) outFifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (ClearIn),
    .push     (fifoPush),
    .pushData (fifoPushData),
    .pop      (ReadEnIn),
    .headData (DataOut),
    .count    (FifoCountOut),
    .empty    (FifoEmptyOut),
    .full     (FifoFullOut)
  );

  assign StallOut = (stateReg == s_Stall);
  assign ErrorOut = errorReg;

endmodule
